pfd_sync: RTL and testbench

- Clocked, edge-sampled phase-frequency detector for the software PLL.
- Compares rising edges of the reference `link` against the loop oscillator `vco`.
- Emits `up`/`dn` error pulses with active-low complements.
- Emits a 2-bit `setting` bus: bit 0 frames each error pulse; bit 1 gives its direction. The PLL controller times the frame and reads the direction at its rising edge.

---
 rtl/pfd_sync.sv | 107 ++++++++++
 tb/tb_pfd_sync.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pfd_sync.sv
// Edge-sampled phase-frequency detector: synchronizes link/vco, detects rising edges,
// and drives up/dn pulses plus a framed direction bus. Optional pulse cap: PFD_TIMEOUT_EN.
module pfd_sync #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       link,
  input  logic       vco,
  output logic [1:0] setting,
  output logic       up,
  output logic       dn,
  output logic       upb,
  output logic       dnb
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DN   = 2'b10
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] link_sync;
  logic [SYNC_STAGES-1:0] vco_sync;
  logic                   link_hist;
  logic                   vco_hist;
  logic                   ref_ev;
  logic                   fb_ev;
  logic                   timeout;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      link_sync <= '0;
      vco_sync  <= '0;
      link_hist <= 1'b0;
      vco_hist  <= 1'b0;
    end else begin
      link_sync <= {link_sync[SYNC_STAGES-2:0], link};
      vco_sync  <= {vco_sync[SYNC_STAGES-2:0], vco};
      link_hist <= link_sync[SYNC_STAGES-1];
      vco_hist  <= vco_sync[SYNC_STAGES-1];
    end
  end

  assign ref_ev = link_sync[SYNC_STAGES-1] & ~link_hist;
  assign fb_ev  = vco_sync[SYNC_STAGES-1] & ~vco_hist;

`ifdef PFD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] pulse_cnt;

  // Count holds the number of cycles already spent in the current pulse (1 on entry).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                  pulse_cnt <= '0;
    else if (state_nxt == IDLE) pulse_cnt <= '0;
    else if (state == IDLE)     pulse_cnt <= CW'(1);
    else                        pulse_cnt <= pulse_cnt + CW'(1);
  end

  assign timeout = (state != IDLE) && (pulse_cnt == CW'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // A pulse always falls back to IDLE; UP<->DN is never taken directly.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ref_ev && !fb_ev)      state_nxt = UP;
          else if (fb_ev && !ref_ev) state_nxt = DN;
        end
        UP:      if (fb_ev)  state_nxt = IDLE;
        DN:      if (ref_ev) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered alongside the state so they switch on the same edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      up      <= 1'b0;
      dn      <= 1'b0;
      upb     <= 1'b1;
      dnb     <= 1'b1;
      setting <= 2'b00;
    end else begin
      state      <= state_nxt;
      up         <= (state_nxt == UP);
      dn         <= (state_nxt == DN);
      upb        <= (state_nxt != UP);
      dnb        <= (state_nxt != DN);
      setting[0] <= (state_nxt != IDLE);
      if (state_nxt == DN)      setting[1] <= 1'b1;
      else if (state_nxt == UP) setting[1] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pfd_sync.sv
// Bench for pfd_sync: directed vector table, hand sequences and random stimulus
// checked cycle by cycle against a delay-queue reference model.
module tb_pfd_sync;

  localparam int SS = 2;
  localparam int TO = 8;
`ifdef PFD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [5:0] RST_OUT = 6'b000011;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       link = 1'b0;
  logic       vco = 1'b0;
  logic [1:0] setting;
  logic       up, dn, upb, dnb;

  int errors = 0;
  int checks = 0;

  // scoreboard: expected {setting, up, dn, upb, dnb}
  logic [5:0] exp_q[$];

  // reference model: raw per-edge samples since reset release
  bit ls[$];
  bit vs[$];
  int m_dir;      // +1 up pulse, -1 dn pulse, 0 none
  int m_len;
  bit m_dirbit;

  int   up_cnt, dn_cnt, rise_cnt;
  logic prev_s0;

  pfd_sync #(.SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nrst(nrst), .link(link), .vco(vco),
    .setting(setting), .up(up), .dn(dn), .upb(upb), .dnb(dnb)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit l, input bit v);
    int i;
    bit r, f;
    ls.push_back(l);
    vs.push_back(v);
    // an edge sampled at edge n acts on the pulse at edge n+SS
    i = ls.size() - 1 - SS;
    r = (i >= 0) ? (ls[i] && !((i >= 1) ? ls[i-1] : 1'b0)) : 1'b0;
    f = (i >= 0) ? (vs[i] && !((i >= 1) ? vs[i-1] : 1'b0)) : 1'b0;
    if (m_dir == 0) begin
      if (r && !f) begin m_dir = 1;  m_len = 1; m_dirbit = 1'b0; end
      else if (f && !r) begin m_dir = -1; m_len = 1; m_dirbit = 1'b1; end
    end else if (TO_EN && m_len == TO) begin
      m_dir = 0; m_len = 0;
    end else if ((m_dir == 1 && f) || (m_dir == -1 && r)) begin
      m_dir = 0; m_len = 0;
    end else begin
      m_len++;
    end
    exp_q.push_back({m_dirbit, m_dir != 0, m_dir == 1, m_dir == -1, m_dir != 1, m_dir != -1});
  endtask

  task automatic check_out(input string name);
    logic [5:0] act;
    logic [5:0] exp;
    act = {setting, up, dn, upb, dnb};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %b with no expected value queued", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", name, act, exp);
      end
    end
    if (up) up_cnt++;
    if (dn) dn_cnt++;
    if (setting[0] && !prev_s0) rise_cnt++;
    prev_s0 = setting[0];
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input bit l, input bit v);
    link = l;
    vco  = v;
    @(posedge clk);
    model_edge(l, v);
    @(negedge clk);
    check_out("cycle");
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    ls.delete(); vs.delete(); exp_q.delete();
    m_dir = 0; m_len = 0; m_dirbit = 1'b0;
    up_cnt = 0; dn_cnt = 0; rise_cnt = 0; prev_s0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      link = 1'($urandom_range(0, 1));
      vco  = 1'($urandom_range(0, 1));
      @(negedge clk);
      cmp("reset_outputs", int'({setting, up, dn, upb, dnb}), int'(RST_OUT));
    end
    link = 1'b0;
    vco  = 1'b0;
    nrst = 1'b1;
  endtask

  typedef struct {
    int         t_link;
    int         t_vco;
    int         up_n;
    int         dn_n;
    int         rises;
    logic [1:0] set_end;
  } vec_t;

  vec_t vt[6];

  initial begin
    // first edge at which each input is sampled high (1000 = never)
    vt[0] = '{t_link: 10, t_vco: 15, up_n: 5, dn_n: 0, rises: 1, set_end: 2'b00};
    vt[1] = '{t_link: 23, t_vco: 20, up_n: 0, dn_n: 3, rises: 1, set_end: 2'b10};
    vt[2] = '{t_link: 10, t_vco: 10, up_n: 0, dn_n: 0, rises: 0, set_end: 2'b00};
    vt[3] = '{t_link: 5,  t_vco: 6,  up_n: 1, dn_n: 0, rises: 1, set_end: 2'b00};
    vt[4] = '{t_link: 9,  t_vco: 8,  up_n: 0, dn_n: 1, rises: 1, set_end: 2'b10};
    vt[5] = '{t_link: 1,  t_vco: 4,  up_n: 3, dn_n: 0, rises: 1, set_end: 2'b00};

    @(negedge clk);
    for (int n = 0; n < 6; n++) begin
      do_reset();
      for (int k = 1; k <= 30; k++) step(k >= vt[n].t_link, k >= vt[n].t_vco);
      cmp($sformatf("vec%0d_up_cycles", n), up_cnt, vt[n].up_n);
      cmp($sformatf("vec%0d_dn_cycles", n), dn_cnt, vt[n].dn_n);
      cmp($sformatf("vec%0d_pulses", n), rise_cnt, vt[n].rises);
      cmp($sformatf("vec%0d_setting_end", n), int'(setting), int'(vt[n].set_end));
    end

    // frequency detect: three link rises before the vco edge give one long pulse
    do_reset();
    for (int k = 1; k <= 25; k++) step(k == 3 || k == 5 || k >= 7, k >= 8);
    cmp("freq_up_cycles", up_cnt, 5);
    cmp("freq_pulses", rise_cnt, 1);

    // mid-pulse reset drops up without waiting for a clock edge
    do_reset();
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0);
    cmp("pre_abort_up", int'(up), 1);
    #2 nrst = 1'b0;
    #1 cmp("abort_outputs", int'({setting, up, dn, upb, dnb}), int'(RST_OUT));

`ifdef PFD_TIMEOUT_EN
    do_reset();
    for (int k = 1; k <= 30; k++) step(k >= 2, 1'b0);
    cmp("timeout_up_cycles", up_cnt, TO);
    cmp("timeout_pulses", rise_cnt, 1);
    do_reset();
    for (int k = 1; k <= 30; k++) step(1'b0, k >= 2);
    cmp("timeout_dn_cycles", dn_cnt, TO);
    cmp("timeout_setting_end", int'(setting), 2);
`endif

    // random toggling against the model
    for (int b = 0; b < 20; b++) begin
      bit l, v;
      do_reset();
      l = 1'b0;
      v = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(0, 4) == 0) l = ~l;
        if ($urandom_range(0, 4) == 0) v = ~v;
        step(l, v);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
